// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), LSB first, idle high.
// The line is synchronized, then the start bit is validated at mid-bit. Each data bit is
// sampled at mid-bit and the stop bit is checked. Every good byte is presented with a
// one-cycle data_valid pulse.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop).
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       rx_busy,
  output logic       frame_error,
  output logic       parity_error
);

  localparam logic [CNT_W-1:0] HalfCnt = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StRecover
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_q, parity_d;
  logic             parity_error_q, parity_error_d;
`endif

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath registers: bit-period counter, bit index, shift register, output byte, pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      data_q         <= 8'h00;
      data_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q       <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      frame_error_q  <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      parity_q       <= parity_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  // Next-state and datapath update; terminal counts always clear the counter.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    frame_error_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d       = parity_q;
    parity_error_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            // Start bit did not hold to mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == FullCnt) begin
          cnt_d    = '0;
          parity_d = rx_s;
          state_d  = StStop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d = '0;
          if (!rx_s) begin
            // Frame error wins over parity; wait out any break before re-arming.
            frame_error_d = 1'b1;
            state_d       = StRecover;
          end
`ifdef UART_RX_PARITY_EN
          else if (parity_q != ^shift_q) begin
            parity_error_d = 1'b1;
            state_d        = StIdle;
          end
`endif
          else begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRecover: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    rx_busy      = (state_q != StIdle) && (state_q != StRecover);
    data         = data_q;
    data_valid   = data_valid_q;
    frame_error  = frame_error_q;
`ifdef UART_RX_PARITY_EN
    parity_error = parity_error_q;
`else
    parity_error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks/bit: directed frames plus random frames, with a
// scoreboard of expected pulses checked by an independent monitor.
module tb_uart_receiver;

  localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBits = 10;
`else
  localparam int unsigned NBits = 9;
`endif
  // Start edge to pulse: sync + half bit + remaining frame bits, plus a small fixed overhead.
  localparam longint LatNom = 2 + (Cpb - 1) / 2 + NBits * Cpb + 1;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       rx_busy;
  logic       frame_error;
  logic       parity_error;

  uart_receiver #(
    .CLKS_PER_BIT(Cpb),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
    .parity_error(parity_error)
  );

  typedef enum int {EvValid, EvFerr, EvPerr} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    longint     start;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_pulse = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    ev_t    e;
    longint lat;
    if (!reset && (data_valid || frame_error || parity_error)) begin
      chk("pulse_onehot", $countones({data_valid, frame_error, parity_error}), 1);
      chk("pulse_width", {31'd0, prev_pulse}, 0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got dv=%b fe=%b pe=%b data=%0h expected no pulse",
                 data_valid, frame_error, parity_error, data);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", data_valid ? EvValid : (frame_error ? EvFerr : EvPerr), e.kind);
        chk("pulse_data", {24'd0, data}, {24'd0, e.data});
        lat = cyc - e.start;
        checks++;
        if (lat < LatNom - 2 || lat > LatNom + 2) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d +/-2", lat, LatNom);
        end
      end
    end
    prev_pulse = data_valid || frame_error || parity_error;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; the expected outcome follows from stop level, then parity.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    ev_t e;
    e.start = cyc;
    if (!stop) begin
      e.kind = EvFerr;
      e.data = model_data;
`ifdef UART_RX_PARITY_EN
    end else if (par_flip) begin
      e.kind = EvPerr;
      e.data = model_data;
`endif
    end else begin
      e.kind     = EvValid;
      e.data     = b;
      model_data = b;
    end
    exp_q.push_back(e);
    drive_bit(1'b0);
    chk("busy_after_start", {31'd0, rx_busy}, 1);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    chk("busy_before_stop", {31'd0, rx_busy}, 1);
    drive_bit(stop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         gap;
    logic       err;
    logic       pf;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, data}, 0);
    chk("reset_valid", {31'd0, data_valid}, 0);
    chk("reset_busy", {31'd0, rx_busy}, 0);
    chk("reset_ferr", {31'd0, frame_error}, 0);
    chk("reset_perr", {31'd0, parity_error}, 0);
    reset = 1'b0;
    idle(20);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_busy_rise", {31'd0, rx_busy}, 1);
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("glitch_busy_drop", {31'd0, rx_busy}, 0);
    chk("glitch_data", {24'd0, data}, 0);
    idle(20);

    // Bad stop bit followed by a long break, then a good byte.
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("break_no_start", {31'd0, rx_busy}, 0);
    chk("break_data_held", {24'd0, data}, 0);
    idle(2 * Cpb);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(10);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(10);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(10);
`endif

    // Reset in the middle of bit 4 of 8'hC3; the frame is abandoned.
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (Cpb / 2) @(posedge clk);
    #1;
    reset      = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_data", {24'd0, data}, 0);
    chk("midreset_busy", {31'd0, rx_busy}, 0);
    idle(2 * Cpb);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(10);

    // Random frames with random gaps, occasional frame and parity errors.
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      err = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 4) == 0);
`else
      pf = 1'b0;
`endif
      send_frame(b, !err, pf);
      if (err) begin
        gap = $urandom_range(0, 30);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        idle(4);
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      idle(gap);
    end

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
